// File: rtl/ufm_burst_streamer_pkg.sv
// Shared types for the UFM burst streamer: FSM encoding, address/length widths
// and the FIFO entry layout (last flag + data byte).
package efbutils;

    localparam int unsigned UfmAddrW = 15;
    localparam int unsigned LenW     = 16;
    localparam int unsigned EntryW   = 9;

    typedef logic [UfmAddrW-1:0] ufm_addr_t;
    typedef logic [LenW-1:0]     burst_len_t;

    typedef enum logic [2:0] {
        StIdle,
        StReq,
        StHold,
        StDrain,
        StAbort
    } burst_state_e;

    typedef struct packed {
        logic       last;
        logic [7:0] data;
    } fifo_entry_t;

endpackage

// File: rtl/ufm_burst_streamer_byte_fifo.sv
// Small power-of-two FIFO holding {last, byte} entries, with synchronous flush
// and an occupancy count.
module byte_fifo
    import efbutils::*;
#(
    parameter int unsigned DEPTH = 4,
    localparam int unsigned PtrW = $clog2(DEPTH),
    localparam int unsigned CntW = PtrW + 1
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              flush_i,
    input  logic              push_i,
    input  logic [EntryW-1:0] wdata_i,
    input  logic              pop_i,
    output logic [EntryW-1:0] rdata_o,
    output logic              empty_o,
    output logic [CntW-1:0]   occupancy_o
);

    logic [EntryW-1:0] mem_q [DEPTH];
    logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]   count_q, count_d;
    logic              full;
    logic              do_push;
    logic              do_pop;

    assign empty_o     = (count_q == '0);
    assign full        = (count_q == CntW'(DEPTH));
    assign occupancy_o = count_q;
    assign rdata_o     = mem_q[rd_ptr_q];

    assign do_pop  = pop_i & ~empty_o;
    // A push at full is only legal when a pop frees a slot in the same cycle.
    assign do_push = push_i & (~full | do_pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) begin
                wr_ptr_d = wr_ptr_q + PtrW'(1);
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + PtrW'(1);
            end
            unique case ({do_push, do_pop})
                2'b10:   count_d = count_q + CntW'(1);
                2'b01:   count_d = count_q - CntW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push && !flush_i) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

endmodule

// File: rtl/ufm_burst_streamer.sv
// Streams a burst of bytes from the UFM page-buffered reader into a small
// output FIFO, one outstanding read at a time, with abort and backpressure.
module ufm_burst_streamer
    import efbutils::*;
#(
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                cmd_stb,
    input  logic [UfmAddrW-1:0] cmd_addr,
    input  logic [LenW-1:0]     cmd_len,
    output logic                cmd_ready,
    input  logic                abort,
    output logic [UfmAddrW-1:0] ufm_addr,
    output logic                read_en,
    input  logic [7:0]          ufm_data,
    input  logic                ufm_valid,
    output logic [7:0]          out_data,
    output logic                out_valid,
    input  logic                out_ready,
    output logic                out_last,
    output logic                busy
);

    localparam int unsigned OccW = $clog2(FIFO_DEPTH) + 1;

    burst_state_e state_q, state_d;
    ufm_addr_t    addr_q, addr_d;
    burst_len_t   remaining_q, remaining_d;
    logic         read_en_q;
    logic         busy_q;
    logic         cmd_ready_q;

    logic              fifo_push;
    logic              fifo_pop;
    logic              fifo_flush;
    logic              fifo_empty;
    logic [OccW-1:0]   fifo_occ;
    fifo_entry_t       fifo_wentry;
    logic [EntryW-1:0] fifo_rdata;
    fifo_entry_t       fifo_rentry;

    logic sample;
    logic last_pop;

    assign fifo_rentry = fifo_entry_t'(fifo_rdata);
    assign out_valid   = ~fifo_empty;
    assign out_data    = out_valid ? fifo_rentry.data : 8'h00;
    assign out_last    = out_valid & fifo_rentry.last;
    assign fifo_pop    = out_valid & out_ready;

    assign ufm_addr  = addr_q;
    assign read_en   = read_en_q;
    assign busy      = busy_q;
    assign cmd_ready = cmd_ready_q;

    // Read data is only trusted while our request is actually asserted.
    assign sample   = read_en_q & ufm_valid;
    assign last_pop = fifo_pop & fifo_rentry.last;

    always_comb begin
        state_d          = state_q;
        addr_d           = addr_q;
        remaining_d      = remaining_q;
        fifo_push        = 1'b0;
        fifo_flush       = 1'b0;
        fifo_wentry.last = (remaining_q == LenW'(1));
        fifo_wentry.data = ufm_data;

        unique case (state_q)
            StIdle: begin
                if (cmd_stb && !abort && (cmd_len != '0)) begin
                    addr_d      = cmd_addr;
                    remaining_d = cmd_len;
                    state_d     = StReq;
                end
            end
            StReq: begin
                if (abort) begin
                    // A read completing together with abort is simply dropped.
                    fifo_flush  = 1'b1;
                    remaining_d = '0;
                    state_d     = sample ? StIdle : StAbort;
                end else if (sample) begin
                    fifo_push   = 1'b1;
                    addr_d      = addr_q + ufm_addr_t'(1);
                    remaining_d = remaining_q - LenW'(1);
                    state_d     = StHold;
                end
            end
            StHold: begin
                if (abort) begin
                    fifo_flush  = 1'b1;
                    remaining_d = '0;
                    state_d     = StIdle;
                end else if (remaining_q == '0) begin
                    state_d = last_pop ? StIdle : StDrain;
                end else if (fifo_occ < OccW'(FIFO_DEPTH)) begin
                    state_d = StReq;
                end
            end
            StDrain: begin
                if (abort) begin
                    fifo_flush = 1'b1;
                    state_d    = StIdle;
                end else if (last_pop || fifo_empty) begin
                    state_d = StIdle;
                end
            end
            StAbort: begin
                // Keep the request up until the reader answers, then discard.
                if (sample) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= StIdle;
            addr_q      <= '0;
            remaining_q <= '0;
            read_en_q   <= 1'b0;
            busy_q      <= 1'b0;
            cmd_ready_q <= 1'b1;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            remaining_q <= remaining_d;
            read_en_q   <= (state_d == StReq) || (state_d == StAbort);
            busy_q      <= (state_d != StIdle);
            cmd_ready_q <= (state_d == StIdle);
        end
    end

    byte_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i       (clk),
        .rst_ni      (rst),
        .flush_i     (fifo_flush),
        .push_i      (fifo_push),
        .wdata_i     (fifo_wentry),
        .pop_i       (fifo_pop),
        .rdata_o     (fifo_rdata),
        .empty_o     (fifo_empty),
        .occupancy_o (fifo_occ)
    );

endmodule

// File: tb/tb_ufm_burst_streamer.sv
// Scoreboard bench for ufm_burst_streamer: a UFM reader model with programmable
// latency, an expected-byte queue, and a monitor on the output handshake.
module tb_ufm_burst_streamer;
    import efbutils::*;

    localparam int unsigned FifoDepth = 4;

    logic        clk;
    logic        rst;
    logic        cmd_stb;
    logic [14:0] cmd_addr;
    logic [15:0] cmd_len;
    logic        cmd_ready;
    logic        abort;
    logic [14:0] ufm_addr;
    logic        read_en;
    logic [7:0]  ufm_data;
    logic        ufm_valid;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        out_ready;
    logic        out_last;
    logic        busy;

    int          checks = 0;
    int          errors = 0;
    logic [8:0]  exp_q[$];
    logic [14:0] addr_log[$];
    int          reads_done = 0;
    int          ufm_lat = 3;
    bit          lat_check = 0;
    int          wait_cnt = 0;
    logic [8:0]  mon_e;

    ufm_burst_streamer #(
        .FIFO_DEPTH (FifoDepth)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_stb   (cmd_stb),
        .cmd_addr  (cmd_addr),
        .cmd_len   (cmd_len),
        .cmd_ready (cmd_ready),
        .abort     (abort),
        .ufm_addr  (ufm_addr),
        .read_en   (read_en),
        .ufm_data  (ufm_data),
        .ufm_valid (ufm_valid),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_last  (out_last),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] mem_byte(input logic [14:0] a);
        return a[7:0] ^ {1'b0, a[14:8]} ^ 8'h3C;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    task automatic push_exp(input logic [14:0] a, input int n, input int len);
        logic [14:0] ai;
        logic        lst;
        for (int i = 0; i < n; i++) begin
            ai  = a + 15'(i);
            lst = (i == len - 1);
            exp_q.push_back({lst, mem_byte(ai)});
        end
    endtask

    task automatic issue(input logic [14:0] a, input logic [15:0] len);
        @(posedge clk);
        #2;
        check("cmd_ready_idle", cmd_ready, 1);
        cmd_stb  = 1'b1;
        cmd_addr = a;
        cmd_len  = len;
        @(posedge clk);
        #2;
        cmd_stb = 1'b0;
        check("first_read_en", read_en, (len != 16'd0));
    endtask

    task automatic wait_idle(input string name);
        bit done;
        done = 0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (!busy && exp_q.size() == 0) begin
                done = 1;
                break;
            end
        end
        check(name, done, 1);
    endtask

    task automatic chk_reset();
        check("rst_read_en", read_en, 0);
        check("rst_ufm_addr", ufm_addr, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_last", out_last, 0);
        check("rst_busy", busy, 0);
        check("rst_cmd_ready", cmd_ready, 1);
    endtask

    // UFM reader model: answers a held read_en after ufm_lat cycles.
    initial begin
        ufm_valid = 1'b0;
        ufm_data  = 8'h00;
        forever begin
            @(posedge clk);
            #1;
            if (!rst) begin
                ufm_valid = 1'b0;
                wait_cnt  = 0;
            end else if (ufm_valid) begin
                ufm_valid = 1'b0;
                wait_cnt  = 0;
                check("read_en_drop", read_en, 0);
                if (lat_check) check("byte_latency", out_valid, 1);
            end else if (read_en) begin
                wait_cnt++;
                if (wait_cnt >= ufm_lat) begin
                    ufm_valid = 1'b1;
                    ufm_data  = mem_byte(ufm_addr);
                    addr_log.push_back(ufm_addr);
                    reads_done++;
                end
            end
        end
    end

    // Monitor: every transferred byte must match the head of the expected queue.
    always @(negedge clk) begin
        if (rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_byte: got %0h last %0b, required no byte",
                         out_data, out_last);
            end else begin
                mon_e = exp_q.pop_front();
                check("out_byte", {out_last, out_data}, mon_e);
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1);
    end

    initial begin
        int  r0;
        bit  seen;
        bit  found;
        bit  held;
        bit  idle;
        logic [14:0] wrap_exp [4];
        wrap_exp = '{15'h7FFE, 15'h7FFF, 15'h0000, 15'h0001};

        rst       = 1'b0;
        cmd_stb   = 1'b0;
        cmd_addr  = '0;
        cmd_len   = '0;
        abort     = 1'b0;
        out_ready = 1'b1;
        #12;
        chk_reset();
        #11;
        rst = 1'b1;
        repeat (2) @(posedge clk);

        // Zero-length command is accepted and ignored.
        issue(15'h0055, 16'd0);
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (read_en || busy || out_valid) seen = 1;
        end
        check("len0_no_activity", seen, 0);

        // Basic burst: 0x10..0x13, latency 3, out_last on 4th byte only.
        ufm_lat   = 3;
        lat_check = 1;
        push_exp(15'h0010, 4, 4);
        issue(15'h0010, 16'd4);
        seen = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (out_valid && out_ready && out_last) begin
                seen = 1;
                break;
            end
        end
        check("last_seen", seen, 1);
        @(negedge clk);
        check("busy_drop", busy, 0);
        check("basic_queue_empty", exp_q.size(), 0);
        lat_check = 0;

        // Address wrap across 0x7FFF.
        addr_log.delete();
        push_exp(15'h7FFE, 4, 4);
        issue(15'h7FFE, 16'd4);
        wait_idle("wrap_done");
        check("wrap_reads", addr_log.size(), 4);
        for (int i = 0; i < 4; i++) begin
            if (i < addr_log.size()) check("wrap_addr", addr_log[i], wrap_exp[i]);
        end

        // Backpressure: FIFO fills after exactly FifoDepth reads.
        ufm_lat   = 1;
        out_ready = 1'b0;
        r0        = reads_done;
        push_exp(15'h0200, 10, 10);
        issue(15'h0200, 16'd10);
        repeat (30) @(negedge clk);
        check("bp_reads", reads_done - r0, FifoDepth);
        check("bp_read_en_low", read_en, 0);
        check("bp_out_valid", out_valid, 1);
        check("bp_busy", busy, 1);
        out_ready = 1'b1;
        wait_idle("bp_done");
        check("bp_total_reads", reads_done - r0, 10);

        // Abort in HOLD with a full FIFO flushes it at once.
        out_ready = 1'b0;
        issue(15'h0300, 16'd6);
        repeat (20) @(negedge clk);
        @(posedge clk);
        #2;
        abort = 1'b1;
        @(posedge clk);
        #2;
        abort = 1'b0;
        check("hold_abort_out_valid", out_valid, 0);
        check("hold_abort_busy", busy, 0);
        check("hold_abort_read_en", read_en, 0);
        out_ready = 1'b1;
        repeat (5) @(negedge clk);

        // Abort while the 3rd of 8 reads is outstanding.
        ufm_lat = 3;
        r0      = reads_done;
        push_exp(15'h0100, 2, 8);
        issue(15'h0100, 16'd8);
        found = 0;
        for (int i = 0; i < 200; i++) begin
            @(posedge clk);
            #2;
            if ((reads_done - r0 == 2) && read_en && !ufm_valid) begin
                found = 1;
                break;
            end
        end
        check("abort_point_reached", found, 1);
        abort = 1'b1;
        @(posedge clk);
        #2;
        abort = 1'b0;
        check("abort_read_en_held", read_en, 1);
        check("abort_out_valid", out_valid, 0);
        held = 1;
        idle = 0;
        for (int i = 0; i < 50; i++) begin
            @(posedge clk);
            #2;
            if (!busy) begin
                idle = 1;
                break;
            end
            if (!read_en) held = 0;
        end
        check("abort_held_until_valid", held, 1);
        check("abort_to_idle", idle, 1);
        check("abort_inflight_read_done", reads_done - r0, 3);
        check("abort_byte_dropped", out_valid, 0);
        check("abort_queue_empty", exp_q.size(), 0);
        push_exp(15'h0020, 2, 2);
        issue(15'h0020, 16'd2);
        wait_idle("after_abort_done");

        // Reset mid-burst returns outputs to reset values immediately.
        out_ready = 1'b0;
        issue(15'h0400, 16'd8);
        repeat (8) @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        chk_reset();
        #10;
        rst       = 1'b1;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        push_exp(15'h7FFF, 3, 3);
        issue(15'h7FFF, 16'd3);
        wait_idle("post_reset_done");

        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ufm_burst_streamer.md
UFM_BURST_STREAMER -- requirements
Module: ufm_burst_streamer

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, meaning output FIFO entries; power of two, 2..16.
REQ-002 SHALL have port clk  in  1  sole clock, all logic on rising edge.
REQ-003 SHALL have port rst  in  1  reset, asynchronous, active-low.
REQ-004 SHALL have ports cmd_stb in 1 (start burst), cmd_addr in 15 (first UFM byte address), cmd_len in 16 (byte count, 0..32768), cmd_ready out 1 (command accepted when cmd_stb&cmd_ready).
REQ-005 SHALL have port abort  in  1  cancel the current burst.
REQ-006 SHALL have ports ufm_addr out 15, read_en out 1, ufm_data in 8, ufm_valid in 1, all to the UFM page-buffered reader.
REQ-007 SHALL have ports out_data out 8, out_valid out 1, out_ready in 1, out_last out 1 (final byte of burst), busy out 1.

Function
REQ-008 SHALL use FSM states IDLE, REQ, HOLD, DRAIN, ABORT.
REQ-009 IDLE: cmd_ready=1; on cmd_stb with cmd_len!=0, latch addr/len and go to REQ; cmd_len==0 is accepted and ignored (stays IDLE, no output).
REQ-010 REQ: read_en=1, ufm_addr stable; exactly one read outstanding; on ufm_valid, write ufm_data into FIFO in that cycle, increment addr, decrement remaining.
REQ-011 After ufm_valid, read_en SHALL drop for at least one cycle (state HOLD); HOLD goes to REQ when remaining!=0 and FIFO occupancy < FIFO_DEPTH, to DRAIN when remaining==0, otherwise stays.
REQ-012 Read latency is unbounded; the block SHALL wait in REQ indefinitely, no timeout.
REQ-013 ufm_addr SHALL wrap 0x7FFF -> 0x0000 within a burst.
REQ-014 ufm_data SHALL be sampled only in cycles where read_en and ufm_valid are both high; ufm_valid in any other cycle SHALL be ignored.
REQ-015 FIFO write and read in the same cycle SHALL leave occupancy unchanged; at full, no new read SHALL be issued (REQ-011 guarantees no overflow).
REQ-016 out_valid SHALL equal FIFO not empty; out_data/out_last stable while out_valid&!out_ready; byte transferred on out_valid&out_ready.
REQ-017 out_last SHALL be stored per FIFO entry, set on the byte written when remaining goes 1 -> 0.
REQ-018 DRAIN goes to IDLE on the cycle the last byte is transferred; busy=1 in every state except IDLE.
REQ-019 Latency: first read_en SHALL assert the cycle after command acceptance; byte SHALL appear on out_valid the cycle after its ufm_valid.
REQ-020 abort in REQ SHALL go to ABORT, keeping read_en high until ufm_valid, then discard that byte and go to IDLE; abort in HOLD/DRAIN goes to IDLE next cycle.
REQ-021 Any abort SHALL flush the FIFO so out_valid=0 the cycle after abort is sampled; abort in IDLE has no effect; abort has priority over cmd_stb.

Reset
REQ-022 On rst low, asynchronously: state IDLE, read_en=0, ufm_addr=0, out_valid=0, out_last=0, busy=0, cmd_ready=1, FIFO empty, counters 0.
REQ-023 Reset mid-read SHALL abandon the outstanding read; the UFM reader shares this reset.

Structure
REQ-024 FSM state encoding and UFM address width (15) SHALL live in the shared efbutils package.
REQ-025 FIFO SHALL be a sub-module byte_fifo (data 9 bits = last+byte, parameter DEPTH, occupancy output).

Verification
REQ-026 cmd addr 0x0010 len 4, out_ready=1, UFM latency 3 -> bytes of 0x10..0x13 in order, out_last only on 4th, busy drops the cycle after.
REQ-027 cmd addr 0x7FFE len 4 -> ufm_addr sequence 0x7FFE,0x7FFF,0x0000,0x0001.
REQ-028 out_ready=0, len 10, FIFO_DEPTH 4 -> exactly 4 reads then read_en stays 0; release out_ready -> all 10 bytes, none lost.
REQ-029 abort while read_en high at byte 3 of 8 -> read_en held until ufm_valid, that byte dropped, out_valid 0, IDLE; new cmd accepted.
REQ-030 cmd_len 0 -> no read_en, busy stays 0; rst low mid-burst -> all outputs at reset values immediately.
